// File: rtl/mul_accum.sv
// -----------------------------------------------------------------------------
// mul_accum
//
// Frame accumulator sitting behind the signed 16x16 sequential multiplier.
// Each rising edge of in_valid captures one 32-bit signed product; FRAME_LEN
// products are summed into an ACC_W-bit signed accumulator.
//
// Each completed frame sum:
//   - is presented on acc_out together with a one-cycle acc_valid pulse;
//   - sets a sticky ovf flag if any add within the frame overflowed.
//
// Parameters:
//   ACC_W      accumulator / output width (>= 32)
//   FRAME_LEN  products per frame (2..255)
//
// Ports:
//   CLK        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   clear      in   synchronous abort of the current frame (also clears ovf)
//   in_prod    in   [31:0] signed product
//   in_valid   in   product valid level from the multiplier
//   acc_out    out  [ACC_W-1:0] last completed frame sum
//   acc_valid  out  one-cycle pulse when acc_out updates
//   prod_cnt   out  [7:0] products accepted in the current frame
//   ovf        out  sticky overflow flag
//
// Build option:
//   MUL_ACC_SAT_EN  defined: overflowing adds saturate to the ACC_W range.
//                   undefined: overflowing adds wrap (two's complement).
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | no product accepted yet in this frame (prod_cnt = 0)
// ACCUM | frame in progress, running sum valid
// -----------------------------------------------------------------------------
module mul_accum #(
    parameter int ACC_W     = 40,
    parameter int FRAME_LEN = 4
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [31:0]      in_prod,
    input  logic             in_valid,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    output logic [7:0]       prod_cnt,
    output logic             ovf
);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);
    localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state;
    state_t                  state_nxt;
    logic                    valid_q;
    logic                    accept;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] sum_nxt;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] add_raw;
    logic signed [ACC_W-1:0] add_res;
    logic                    add_ovf;
    logic [7:0]              cnt_nxt;
    logic                    frame_done;
    logic                    ovf_set;

    // Only the 0->1 transition of in_valid counts; a long valid level
    // from the multiplier must not be accumulated more than once.
    assign accept   = in_valid & ~valid_q;
    assign prod_ext = ACC_W'(signed'(in_prod));
    assign add_raw  = sum + prod_ext;

    // Signed overflow: operands agree in sign, result does not.
    assign add_ovf  = (sum[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (add_raw[ACC_W-1] != sum[ACC_W-1]);

`ifdef MUL_ACC_SAT_EN
    // Direction of overflow follows the (shared) operand sign.
    assign add_res = add_ovf ? (sum[ACC_W-1] ? SUM_MIN : SUM_MAX) : add_raw;
`else
    assign add_res = add_raw;
`endif

    always_comb begin
        state_nxt  = state;
        sum_nxt    = sum;
        cnt_nxt    = prod_cnt;
        frame_done = 1'b0;
        ovf_set    = 1'b0;
        if (clear) begin
            // clear takes priority over a coincident product
            state_nxt = IDLE;
            sum_nxt   = '0;
            cnt_nxt   = 8'd0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    // first product replaces whatever the old sum was
                    sum_nxt   = prod_ext;
                    cnt_nxt   = 8'd1;
                    state_nxt = ACCUM;
                end
                ACCUM: begin
                    sum_nxt = add_res;
                    ovf_set = add_ovf;
                    if (prod_cnt == LAST_CNT) begin
                        cnt_nxt    = 8'd0;
                        state_nxt  = IDLE;
                        frame_done = 1'b1;
                    end else begin
                        cnt_nxt = prod_cnt + 8'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            valid_q   <= 1'b0;
            sum       <= '0;
            prod_cnt  <= 8'd0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            valid_q   <= in_valid;
            state     <= state_nxt;
            sum       <= sum_nxt;
            prod_cnt  <= cnt_nxt;
            acc_valid <= frame_done;
            if (frame_done) begin
                acc_out <= sum_nxt;
            end
            if (clear) begin
                ovf <= 1'b0;
            end else if (ovf_set) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
